// File: rtl/seq_subtractor32.sv
`default_nettype none
// ============================================================================
// Module   : seq_subtractor32
// Brief    : Multi-cycle unsigned subtractor, out = a - b (mod 2^WIDTH).
//            Works through CHUNK bits per clock, LSB chunk first, and ripples
//            the borrow through a register. The accepting cycle is followed by
//            N busy cycles, and then by a one-cycle done pulse.
// Options  : `define SUB32_FLAGS_EN adds the registered zero/negative/overflow
//            outputs, which update together with out.
// Revision : 1.0 - initial release
// ============================================================================
module seq_subtractor32 #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrowOut
`ifdef SUB32_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative,
    output logic             overflow
`endif
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_next;
    logic [IDXW-1:0]  r_idx;
    logic             r_borrow;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_diff;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] r_out;
    logic             r_borrow_out;

    // A new operation is taken only when no chunk work is in flight.
    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last   = (r_state == c_BUSY) && (r_idx == c_LAST_IDX);

    // Current chunk pair, taken from the captured operands.
    assign w_a_chunk = r_a[int'(r_idx) * CHUNK +: CHUNK];
    assign w_b_chunk = r_b[int'(r_idx) * CHUNK +: CHUNK];

    // The extra top bit of the CHUNK+1-bit difference is the borrow out of this chunk.
    assign w_diff = {1'b0, w_a_chunk} - {1'b0, w_b_chunk} - {{CHUNK{1'b0}}, r_borrow};

    // Merge the fresh chunk into the partial result so that the last chunk can commit directly.
    always_comb begin
        w_res_next = r_res;
        w_res_next[int'(r_idx) * CHUNK +: CHUNK] = w_diff[CHUNK-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic. A start that arrives while BUSY is simply not looked at.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_BUSY;
            c_BUSY:  if (r_idx == c_LAST_IDX) w_state_next = c_DONE;
            c_DONE:  w_state_next = start ? c_BUSY : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    // Datapath: capture the operands on accept, process one chunk per BUSY cycle, commit on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_res        <= '0;
            r_idx        <= '0;
            r_borrow     <= 1'b0;
            r_out        <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_idx    <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == c_BUSY) begin
            r_res    <= w_res_next;
            r_borrow <= w_diff[CHUNK];
            r_idx    <= r_idx + 1'b1;
            if (w_last) begin
                r_out        <= w_res_next;
                r_borrow_out <= w_diff[CHUNK];
            end
        end
    end

`ifdef SUB32_FLAGS_EN
    logic r_zero;
    logic r_negative;
    logic r_overflow;

    // Status flags are sampled from the same committed result as out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_last && !w_accept) begin
            r_zero     <= (w_res_next == '0);
            r_negative <= w_res_next[WIDTH-1];
            r_overflow <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                          (w_res_next[WIDTH-1] != r_a[WIDTH-1]);
        end
    end

    assign zero     = r_zero;
    assign negative = r_negative;
    assign overflow = r_overflow;
`endif

    assign busy      = (r_state == c_BUSY);
    assign done      = (r_state == c_DONE);
    assign out       = r_out;
    assign borrowOut = r_borrow_out;

endmodule
`default_nettype wire

// File: tb/tb_seq_subtractor32.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_subtractor32
// Brief    : Self-checking bench for seq_subtractor32. It applies a table of
//            known vectors, runs the handshake/reset corner sequences, and
//            then runs random operations that are compared against a
//            reference model based on plain arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_subtractor32;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] out;
    logic        borrowOut;
`ifdef SUB32_FLAGS_EN
    logic        zero;
    logic        negative;
    logic        overflow;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Last committed result that the model expects the DUT to hold.
    logic [31:0] exp_out_q;
    logic        exp_borrow_q;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] exp_out;
        logic        exp_borrow;
        logic        exp_zero;
        logic        exp_neg;
        logic        exp_ovf;
    } vec_t;

    vec_t tab [7];

    seq_subtractor32 #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .out       (out),
        .borrowOut (borrowOut)
`ifdef SUB32_FLAGS_EN
        ,
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
`endif
    );

    always #5 clk = ~clk;

    // Bound the run in case the DUT hangs.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: unsigned modular difference, with borrow whenever x < y.
    function automatic logic [31:0] model_diff(input logic [31:0] x, input logic [31:0] y);
        return x - y;
    endfunction

    function automatic logic model_borrow(input logic [31:0] x, input logic [31:0] y);
        return (x < y);
    endfunction

    function automatic logic model_ovf(input logic [31:0] x, input logic [31:0] y);
        longint r;
        r = longint'($signed(x)) - longint'($signed(y));
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Issue one operation from the current cycle (cycle 0). Optionally pulse start
    // again in cycle pulse_cyc. Returns while the bench sits in the done cycle.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv, input int pulse_cyc);
        int          done_cyc;
        logic [31:0] e_out;
        logic        e_b;
        e_out    = model_diff(ta, tbv);
        e_b      = model_borrow(ta, tbv);
        a        = ta;
        b        = tbv;
        start    = 1'b1;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 3 * N + 4; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == pulse_cyc);
            a     = $urandom;
            b     = $urandom;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            check("busy_phase", {63'd0, busy}, {63'd0, (cyc <= N)});
            check("out_held", {32'd0, out}, {32'd0, exp_out_q});
            check("borrow_held", {63'd0, borrowOut}, {63'd0, exp_borrow_q});
        end
        check("done_cycle", 64'(done_cyc), 64'(N + 1));
        check("busy_in_done", {63'd0, busy}, 64'd0);
        check("out", {32'd0, out}, {32'd0, e_out});
        check("borrowOut", {63'd0, borrowOut}, {63'd0, e_b});
`ifdef SUB32_FLAGS_EN
        check("zero", {63'd0, zero}, {63'd0, (e_out == 32'd0)});
        check("negative", {63'd0, negative}, {63'd0, e_out[31]});
        check("overflow", {63'd0, overflow}, {63'd0, model_ovf(ta, tbv)});
`endif
        exp_out_q    = e_out;
        exp_borrow_q = e_b;
    endtask

    // One cycle with no start: the DUT must be idle and holding its result.
    task automatic idle_check();
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done", {63'd0, done}, 64'd0);
        check("idle_busy", {63'd0, busy}, 64'd0);
        check("idle_out", {32'd0, out}, {32'd0, exp_out_q});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int          mode;

        tab[0] = '{32'd10,         32'd3,          32'd7,          1'b0, 1'b0, 1'b0, 1'b0};
        tab[1] = '{32'd3,          32'd10,         32'hFFFF_FFF9,  1'b1, 1'b0, 1'b1, 1'b0};
        tab[2] = '{32'h0000_0100,  32'd1,          32'h0000_00FF,  1'b0, 1'b0, 1'b0, 1'b0};
        tab[3] = '{32'd0,          32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0, 1'b0, 1'b0};
        tab[4] = '{32'd5,          32'd5,          32'd0,          1'b0, 1'b1, 1'b0, 1'b0};
        tab[5] = '{32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0, 1'b0, 1'b0, 1'b1};
        tab[6] = '{32'h0000_1234,  32'h0000_1234,  32'd0,          1'b0, 1'b1, 1'b0, 1'b0};

        rst          = 1'b1;
        start        = 1'b0;
        a            = 32'd0;
        b            = 32'd0;
        exp_out_q    = 32'd0;
        exp_borrow_q = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_out", {32'd0, out}, 64'd0);
        check("reset_borrow", {63'd0, borrowOut}, 64'd0);
`ifdef SUB32_FLAGS_EN
        check("reset_zero", {63'd0, zero}, 64'd0);
        check("reset_negative", {63'd0, negative}, 64'd0);
        check("reset_overflow", {63'd0, overflow}, 64'd0);
`endif
        rst = 1'b0;
        idle_check();

        // Known vectors, each one followed by an idle cycle.
        for (int i = 0; i < 7; i++) begin
            run_op(tab[i].va, tab[i].vb, 0);
            check("tab_out", {32'd0, out}, {32'd0, tab[i].exp_out});
            check("tab_borrow", {63'd0, borrowOut}, {63'd0, tab[i].exp_borrow});
`ifdef SUB32_FLAGS_EN
            check("tab_zero", {63'd0, zero}, {63'd0, tab[i].exp_zero});
            check("tab_negative", {63'd0, negative}, {63'd0, tab[i].exp_neg});
            check("tab_overflow", {63'd0, overflow}, {63'd0, tab[i].exp_ovf});
`endif
            idle_check();
        end

        // Full borrow chain, then a back-to-back op with start held in the done cycle.
        run_op(32'd0, 32'hFFFF_FFFF, 0);
        run_op(32'd5, 32'd5, 0);
        idle_check();

        // A start that arrives while busy must be ignored: one done only.
        run_op(32'd10, 32'd3, 2);
        repeat (3) idle_check();

        // A reset in the middle of an operation aborts it with no done pulse.
        run_op(32'd3, 32'd10, 0);
        idle_check();
        a     = 32'h55;
        b     = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_done", {63'd0, done}, 64'd0);
        check("rst_mid_out", {32'd0, out}, 64'd0);
        check("rst_mid_borrow", {63'd0, borrowOut}, 64'd0);
        exp_out_q    = 32'd0;
        exp_borrow_q = 1'b0;
        repeat (N + 3) idle_check();

        // Random operations, with a mix of equal, adjacent and extreme operands.
        for (int k = 0; k < 60; k++) begin
            mode = $urandom_range(0, 4);
            ra   = $urandom;
            rb   = $urandom;
            case (mode)
                1: rb = ra;
                2: rb = ra + 32'd1;
                3: begin ra = {$urandom_range(0, 1) ? 8'hFF : 8'h00, 24'd0}; rb = 32'hFF; end
                4: rb = {ra[31:8], ra[7:0] + 8'd1};
                default: ;
            endcase
            run_op(ra, rb, ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, N)) : 0);
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
